// File: rtl/madnes_video_pkg.sv
// rtl/madnes_video_pkg.sv - 640x480@60 timing constants and video pixel types
package madnes_video_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - h/v counters and stage-0 active/sync/frame decode
module video_timing_gen #(
  parameter int H_ACTIVE = madnes_video_pkg::H_ACTIVE,
  parameter int H_FP     = madnes_video_pkg::H_FP,
  parameter int H_SYNC   = madnes_video_pkg::H_SYNC,
  parameter int H_TOTAL  = madnes_video_pkg::H_TOTAL,
  parameter int V_ACTIVE = madnes_video_pkg::V_ACTIVE,
  parameter int V_FP     = madnes_video_pkg::V_FP,
  parameter int V_SYNC   = madnes_video_pkg::V_SYNC,
  parameter int V_TOTAL  = madnes_video_pkg::V_TOTAL
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  output madnes_video_pkg::coord_t h,
  output madnes_video_pkg::coord_t v,
  output logic                     active,
  output logic                     hs_n,
  output logic                     vs_n,
  output logic                     frame_start,
  output logic                     vblank
);
  import madnes_video_pkg::*;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h <= '0;
      v <= '0;
    end else if (ce) begin
      if (h == coord_t'(H_TOTAL - 1)) begin
        h <= '0;
        v <= (v == coord_t'(V_TOTAL - 1)) ? '0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  assign active = (h < coord_t'(H_ACTIVE)) && (v < coord_t'(V_ACTIVE));
  assign hs_n   = !((h >= coord_t'(H_ACTIVE + H_FP)) && (h < coord_t'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_n   = !((v >= coord_t'(V_ACTIVE + V_FP)) && (v < coord_t'(V_ACTIVE + V_FP + V_SYNC)));
  assign vblank = (v >= coord_t'(V_ACTIVE));
  // Gated by rst so the pulse is absent while held in reset yet present on the first ce after release.
  assign frame_start = rst && ce && (h == '0) && (v == '0);

endmodule

// File: rtl/vga_pixel_output.sv
// rtl/vga_pixel_output.sv - VGA timing, renderer/palette alignment pipeline and pin registers
module vga_pixel_output #(
  parameter int H_ACTIVE       = madnes_video_pkg::H_ACTIVE,
  parameter int H_FP           = madnes_video_pkg::H_FP,
  parameter int H_SYNC         = madnes_video_pkg::H_SYNC,
  parameter int H_BP           = madnes_video_pkg::H_BP,
  parameter int V_ACTIVE       = madnes_video_pkg::V_ACTIVE,
  parameter int V_FP           = madnes_video_pkg::V_FP,
  parameter int V_SYNC         = madnes_video_pkg::V_SYNC,
  parameter int V_BP           = madnes_video_pkg::V_BP,
  parameter int RENDER_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_ce,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_active,
  input  logic [8:0]  pixel_index,
  output logic [8:0]  palette_read_addr,
  input  logic [23:0] palette_read_data,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        frame_start,
  output logic        vblank
);
  import madnes_video_pkg::*;

  logic hs_n, vs_n;
  logic [RENDER_LATENCY-1:0] act_dly, hs_dly, vs_dly;
  rgb_t pix;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_TOTAL  (H_ACTIVE + H_FP + H_SYNC + H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_TOTAL  (V_ACTIVE + V_FP + V_SYNC + V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .ce          (pixel_ce),
    .h           (pixel_x),
    .v           (pixel_y),
    .active      (pixel_active),
    .hs_n        (hs_n),
    .vs_n        (vs_n),
    .frame_start (frame_start),
    .vblank      (vblank)
  );

  assign palette_read_addr = pixel_index;

  // Sync stages clear to the deasserted level so no phantom pulse leaves the pipe after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_dly   <= '0;
      hs_dly    <= '1;
      vs_dly    <= '1;
      pix       <= '0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
    end else if (pixel_ce) begin
      act_dly[0] <= pixel_active;
      hs_dly[0]  <= hs_n;
      vs_dly[0]  <= vs_n;
      for (int i = 1; i < RENDER_LATENCY; i++) begin
        act_dly[i] <= act_dly[i-1];
        hs_dly[i]  <= hs_dly[i-1];
        vs_dly[i]  <= vs_dly[i-1];
      end
      pix       <= act_dly[RENDER_LATENCY-1] ? rgb_t'(palette_read_data) : '0;
      vga_hsync <= hs_dly[RENDER_LATENCY-1];
      vga_vsync <= vs_dly[RENDER_LATENCY-1];
    end
  end

  assign vga_r = pix.r;
  assign vga_g = pix.g;
  assign vga_b = pix.b;

endmodule

// File: tb/tb_vga_pixel_output.sv
// tb/tb_vga_pixel_output.sv - bench for vga_pixel_output: full 640x480 RL=1 and reduced-geometry RL=3
module tb_vga_pixel_output;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce  = 1'b1;
  bit   white = 1'b0;
  bit   white_edge = 1'b0;
  int   k = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  logic [9:0]  a_x, a_y, b_x, b_y;
  logic        a_act, a_fs, a_vb, a_hs, a_vs, b_act, b_fs, b_vb, b_hs, b_vs;
  logic [8:0]  a_idx, a_addr, b_idx, b_addr;
  logic [23:0] a_data, b_data;
  logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;
  logic [9:0]  a_hist [4];
  logic [9:0]  b_hist [4];

  vga_pixel_output #(.RENDER_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .pixel_ce(ce),
    .pixel_x(a_x), .pixel_y(a_y), .pixel_active(a_act),
    .pixel_index(a_idx), .palette_read_addr(a_addr), .palette_read_data(a_data),
    .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .vga_hsync(a_hs), .vga_vsync(a_vs),
    .frame_start(a_fs), .vblank(a_vb)
  );

  vga_pixel_output #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .RENDER_LATENCY(3)
  ) dut_b (
    .clk(clk), .rst(rst), .pixel_ce(ce),
    .pixel_x(b_x), .pixel_y(b_y), .pixel_active(b_act),
    .pixel_index(b_idx), .palette_read_addr(b_addr), .palette_read_data(b_data),
    .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .vga_hsync(b_hs), .vga_vsync(b_vs),
    .frame_start(b_fs), .vblank(b_vb)
  );

  // Renderer: index = pixel_x, delayed by its latency in ce cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        a_hist[i] <= '0;
        b_hist[i] <= '0;
      end
    end else if (ce) begin
      a_hist[0] <= a_x;
      b_hist[0] <= b_x;
      for (int i = 1; i < 4; i++) begin
        a_hist[i] <= a_hist[i-1];
        b_hist[i] <= b_hist[i-1];
      end
    end
  end

  assign a_idx  = a_hist[0][8:0];
  assign b_idx  = b_hist[2][8:0];
  assign a_data = white ? 24'hFFFFFF : {a_addr[7:0], 8'hAA, 8'h55};
  assign b_data = white ? 24'hFFFFFF : {b_addr[7:0], 8'hAA, 8'h55};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic check_dut(input string n, input int ha, hfp, hsw, ht, va, vfp, vsw, vt, lat,
                           input logic [9:0] x, y, input logic act, vb, fs,
                           input logic [7:0] r, g, b, input logic hs, vs,
                           input logic [8:0] addr, idx);
    int p, h, v, m;
    logic [23:0] rgb_e;
    logic hs_e, vs_e;
    p = k % (ht * vt);
    h = p % ht;
    v = p / ht;
    chk({n, ".pixel_x"}, 32'(x), h);
    chk({n, ".pixel_y"}, 32'(y), v);
    chk({n, ".pixel_active"}, 32'(act), 32'(h < ha && v < va));
    chk({n, ".vblank"}, 32'(vb), 32'(v >= va));
    chk({n, ".frame_start"}, 32'(fs), 32'(ce && rst && p == 0));
    chk({n, ".read_addr"}, 32'(addr), 32'(idx));
    m = k - (lat + 1);
    if (m < 0) begin
      rgb_e = '0;
      hs_e  = 1'b1;
      vs_e  = 1'b1;
    end else begin
      p = m % (ht * vt);
      h = p % ht;
      v = p / ht;
      rgb_e = (h < ha && v < va) ? (white_edge ? 24'hFFFFFF : {h[7:0], 8'hAA, 8'h55}) : 24'h0;
      hs_e  = !(h >= ha + hfp && h < ha + hfp + hsw);
      vs_e  = !(v >= va + vfp && v < va + vfp + vsw);
    end
    chk({n, ".rgb"}, 32'({r, g, b}), 32'(rgb_e));
    chk({n, ".hsync"}, 32'(hs), 32'(hs_e));
    chk({n, ".vsync"}, 32'(vs), 32'(vs_e));
  endtask

  task automatic check_all();
    check_dut("a", 640, 16, 96, 800, 480, 10, 2, 525, 1,
              a_x, a_y, a_act, a_vb, a_fs, a_r, a_g, a_b, a_hs, a_vs, a_addr, a_idx);
    check_dut("b", 8, 2, 3, 15, 4, 1, 2, 8, 3,
              b_x, b_y, b_act, b_vb, b_fs, b_r, b_g, b_b, b_hs, b_vs, b_addr, b_idx);
  endtask

  task automatic tick(input bit ce_v);
    @(negedge clk);
    ce = ce_v;
    @(posedge clk);
    if (ce_v && rst) begin
      k++;
      white_edge = white;
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    #1;
    check_all();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ce = 1'b1;
    #1;
    check_all();
    @(posedge clk);
    k++;
    white_edge = white;
    #1;
    check_all();
  endtask

  initial begin
    int low_cnt, first_low, fs_prev, period, rst_at;
    low_cnt = 0;
    first_low = -1;
    fs_prev = -1;
    period = -1;

    // Reset held with ce high, then free-run two lines of the full-size raster.
    do_reset();
    for (int i = 0; i < 1699; i++) begin
      tick(1'b1);
      if (k <= 800 && a_hs === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = k;
      end
      if (k == 7) chk("x5_colour", 32'({a_r, a_g, a_b}), 32'h05AA55);
    end
    chk("hsync_width", low_cnt, 96);
    chk("hsync_fall", first_low, 658);

    // Reset in the middle of an hsync pulse.
    while (k < 2300) tick(1'b1);
    chk("pre_reset_hsync", 32'(a_hs), 32'h0);
    do_reset();

    // Blanking with all-white palette data.
    white = 1'b1;
    for (int i = 0; i < 900; i++) tick(1'b1);
    white = 1'b0;

    // ce one clock in four.
    for (int i = 0; i < 1440; i++) begin
      tick(i % 4 == 0);
      if (b_fs === 1'b1) begin
        if (fs_prev >= 0 && period < 0) period = i - fs_prev;
        fs_prev = i;
      end
    end
    chk("fs_period_ce4", period, 480);

    // Random ce, random palette mode, one random reset.
    rst_at = $urandom_range(300, 1500);
    for (int i = 0; i < 2000; i++) begin
      if (i == rst_at) do_reset();
      if ($urandom_range(0, 63) == 0) white = ~white;
      tick(1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_pixel_output.md
Name: vga_pixel_output

Overview:
- Downstream consumer of the palette memory.
- Generates 640x480@60 VGA timing and tells the pixel renderer which pixel to produce.
- Sends the renderer's 9-bit palette index to the palette memory read port, registers the returned 24-bit RGB, and drives the VGA pins.
- Delays sync and blanking so they stay aligned with the colour data.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
RENDER_LATENCY, 1, pixel_ce cycles from pixel_x/pixel_y to a valid pixel_index (1..4)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
pixel_ce  in  1  pixel-rate enable; all pipeline and counter state advances only when high
pixel_x  out  10  stage-0 column to renderer
pixel_y  out  10  stage-0 line to renderer
pixel_active  out  1  stage-0 visible-region flag to renderer
pixel_index  in  9  renderer palette index, valid RENDER_LATENCY ce-cycles after pixel_x/pixel_y
palette_read_addr  out  9  to palette memory read_addr; combinationally equals pixel_index
palette_read_data  in  24  from palette memory, combinational, {R,G,B}
vga_r  out  8  red
vga_g  out  8  green
vga_b  out  8  blue
vga_hsync  out  1  active-low hsync
vga_vsync  out  1  active-low vsync
frame_start  out  1  one-clk pulse at stage 0 when h=0, v=0 and pixel_ce is high
vblank  out  1  stage-0 flag, high while v_count >= V_ACTIVE; used by the CPU for palette writes

Behaviour:
- Reset (rst low, asynchronous) clears:
  - h_count, v_count, all delay stages and RGB to 0.
  - vga_hsync and vga_vsync to 1 (deasserted).
  - frame_start to 0.
  - vblank to 0.
  - pixel_active to 1, because h = v = 0.
- After release, counting resumes on the first clk edge with pixel_ce high.
- Counters:
  - H_TOTAL = 800, V_TOTAL = 525.
  - h_count wraps from H_TOTAL-1 to 0.
  - v_count increments only when h_count wraps, and wraps from V_TOTAL-1 to 0.
  - At h = 799, v = 524 both counters return to 0 together.
- Stage-0 decodes:
  - active = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hs_n low for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs_n low for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- pixel_x, pixel_y and pixel_active are direct counter/decode values and are driven during blanking as well.
- Pipeline:
  - active, hs_n and vs_n pass through a RENDER_LATENCY-deep shift register that advances on pixel_ce.
  - This aligns them with pixel_index.
  - Output register, one more ce-cycle:
    - vga_{r,g,b} <= aligned_active ? palette_read_data : 0.
    - vga_hsync <= aligned hs_n.
    - vga_vsync <= aligned vs_n.
- Total latency from a counter value to the pins is RENDER_LATENCY+1 ce-cycles, identical for colour and sync.
- pixel_ce low: every register holds, outputs are stable, and frame_start stays 0.
- Renderer output during blanking is don't-care; RGB is forced to 0.
- palette_read_addr is passed through without qualification. Out-of-range indices, i.e. palette memory upper half, are the renderer's responsibility.
- Reset mid-frame: immediate return to the reset state. The next frame starts at h = v = 0 with frame_start asserted on the first ce.
- No handshake backpressure exists; the renderer must meet RENDER_LATENCY exactly.

Decomposition:
- Package madnes_video_pkg holds:
  - 640x480 timing localparams and H_TOTAL/V_TOTAL.
  - typedef rgb_t as a packed struct {r, g, b} of 8 bits each.
  - typedef coord_t as logic[9:0].
- Sub-module video_timing_gen contains the counters plus the active/hs_n/vs_n/frame_start/vblank decode.
- The top level holds the delay line and the output register.

Test Plan:
- Reset with rst=0 mid-line, pixel_ce tied high -> outputs 0, hsync=vsync=1 while rst=0; after release, frame_start pulses on the first clk and pixel_x=0, pixel_y=0.
- Free-run one line, pixel_ce tied high -> vga_hsync low for exactly 96 clks; its falling edge comes 656+RENDER_LATENCY+1 clks after the frame_start clk.
- Free-run one frame -> vga_vsync low for exactly 2 lines (1600 clks) starting at line 490; frame_start period is 420000 clks.
- Renderer model returns index = pixel_x[8:0] with latency 1, and palette data = {index[7:0], 8'hAA, 8'h55} -> at pixel x = 5 the pins show R=05, G=AA, B=55 exactly 2 ce-cycles after pixel_x = 5.
- Blanking: palette_read_data forced to 24'hFFFFFF -> RGB = 0 for h >= 640 and for v >= 480; vblank is high on lines 480..524 only.
- pixel_ce asserted 1 clk in 4 -> all timing scales by 4; outputs hold between ce pulses; frame_start width is 1 clk; the RENDER_LATENCY=3 variant still aligns colour with sync.
